// File: rtl/key_turn_queue.sv
// Button front end for the snake core: two-flop sync, per-key debounce, press detect,
// and a small turn-command FIFO that is drained one entry per move tick into the heading.
module key_turn_queue #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int QUEUE_DEPTH     = 2,
  parameter int CNT_W           = 16
) (
  input  logic       clockInp,
  input  logic       reset,
  input  logic [1:0] KEY,
  input  logic       move_tick,
  input  logic       clear,
  output logic       direction,
  output logic       horizontal,
  output logic       vertical,
  output logic       turn_applied,
  output logic [3:0] queue_count,
  output logic       overflow
);

  localparam int              PTR_W      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      LP_DEPTH   = 4'(QUEUE_DEPTH);

  logic [1:0]             r_sync1;
  logic [1:0]             r_sync2;
  logic [1:0]             r_db;
  logic [CNT_W-1:0]       r_cnt [2];
  logic [QUEUE_DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [3:0]             r_count;
  logic                   r_dir;
  logic                   r_hor;
  logic                   r_ver;
  logic                   r_turn_applied;
  logic                   r_overflow;

  logic [1:0] w_settle;
  logic [1:0] w_press;
  logic       w_push_req;
  logic       w_push_code;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  logic       w_head;

  // A key settles when its synced level has differed for DEBOUNCE_CYCLES samples;
  // a settle toward 0 from a released level is the single press event.
  always_comb begin
    w_settle = 2'b00;
    w_press  = 2'b00;
    for (int k = 0; k < 2; k++) begin
      w_settle[k] = (r_sync2[k] != r_db[k]) && (r_cnt[k] == LP_CNT_MAX);
      w_press[k]  = w_settle[k] && r_db[k];
    end
  end

  always_ff @(posedge clockInp or posedge reset) begin
    if (reset) begin
      r_sync1  <= 2'b11;
      r_sync2  <= 2'b11;
      r_db     <= 2'b11;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_db[k]) begin
          r_cnt[k] <= '0;
        end else if (w_settle[k]) begin
          r_db[k]  <= r_sync2[k];
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // Producer side: a press is offered every cycle it occurs, accepted when there is room
  // (a same-cycle pop counts as room). Consumer side: move_tick pops only if non-empty.
  always_comb begin
    w_push_req  = |w_press;
    w_push_code = !w_press[0];
    w_full      = (r_count == LP_DEPTH);
    w_pop       = move_tick && (r_count != 4'd0);
    w_push      = w_push_req && (!w_full || w_pop);
    w_drop      = (&w_press) || (w_push_req && !w_push);
    w_head      = r_mem[r_rd_ptr];
  end

  always_ff @(posedge clockInp or posedge reset) begin
    if (reset) begin
      r_mem          <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= 4'd0;
      r_dir          <= 1'b0;
      r_hor          <= 1'b0;
      r_ver          <= 1'b0;
      r_turn_applied <= 1'b0;
      r_overflow     <= 1'b0;
    end else if (clear) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= 4'd0;
      r_dir          <= 1'b0;
      r_hor          <= 1'b0;
      r_ver          <= 1'b0;
      r_turn_applied <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_turn_applied <= w_pop;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_code;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        // Turn A (code 0) rotates right->up->left->down; B runs the other way.
        if (!r_dir) begin
          r_dir <= 1'b1;
          r_ver <= w_head ? r_hor : !r_hor;
        end else begin
          r_dir <= 1'b0;
          r_hor <= w_head ? !r_ver : r_ver;
        end
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 4'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 4'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign direction    = r_dir;
  assign horizontal   = r_hor;
  assign vertical     = r_ver;
  assign turn_applied = r_turn_applied;
  assign queue_count  = r_count;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_key_turn_queue.sv
// Directed bench for key_turn_queue with a short debounce window and a two-entry queue.
// Heading is viewed as {direction, horizontal, vertical}.
module tb_key_turn_queue;

  logic       clk;
  logic       reset;
  logic [1:0] key;
  logic       move_tick;
  logic       clear;
  logic       direction;
  logic       horizontal;
  logic       vertical;
  logic       turn_applied;
  logic [3:0] queue_count;
  logic       overflow;

  int n_checks;
  int n_errors;
  logic [2:0] exp_q[$];
  logic       seen_ta;

  key_turn_queue #(
    .DEBOUNCE_CYCLES(4),
    .QUEUE_DEPTH(2),
    .CNT_W(16)
  ) dut (
    .clockInp(clk),
    .reset(reset),
    .KEY(key),
    .move_tick(move_tick),
    .clear(clear),
    .direction(direction),
    .horizontal(horizontal),
    .vertical(vertical),
    .turn_applied(turn_applied),
    .queue_count(queue_count),
    .overflow(overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] hd();
    return {direction, horizontal, vertical};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled on the falling edge
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k, input int low_cycles, input int rel_cycles);
    key[k] = 1'b0;
    step(low_cycles);
    key[k] = 1'b1;
    step(rel_cycles);
  endtask

  task automatic do_tick();
    move_tick = 1'b1;
    step(1);
    move_tick = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    key       = 2'b11;
    move_tick = 1'b0;
    clear     = 1'b0;
    step(2);
    check_eq("rst_heading", 32'(hd()), 32'h0);
    check_eq("rst_count", 32'(queue_count), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_turn", 32'(turn_applied), 32'd0);
    reset = 1'b0;

    // idle with keys released
    seen_ta = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      seen_ta = seen_ta | turn_applied;
    end
    check_eq("idle_turn_seen", 32'(seen_ta), 32'd0);
    check_eq("idle_heading", 32'(hd()), 32'h0);
    check_eq("idle_count", 32'(queue_count), 32'd0);

    // single A press: event lands six edges after the key edge
    key[0] = 1'b0;
    step(5);
    check_eq("a_lat_before", 32'(queue_count), 32'd0);
    step(1);
    check_eq("a_lat_at", 32'(queue_count), 32'd1);
    step(14);
    key[0] = 1'b1;
    step(10);
    check_eq("a_hold_once", 32'(queue_count), 32'd1);
    do_tick();
    check_eq("a_heading_up", 32'(hd()), 32'b101);
    check_eq("a_turn_pulse", 32'(turn_applied), 32'd1);
    check_eq("a_count_after", 32'(queue_count), 32'd0);
    step(1);
    check_eq("a_turn_one_cycle", 32'(turn_applied), 32'd0);

    // 3-cycle glitch on B is filtered, then a long hold gives one push
    press(1, 3, 15);
    check_eq("glitch_count", 32'(queue_count), 32'd0);
    key[1] = 1'b0;
    step(40);
    check_eq("b_hold_count", 32'(queue_count), 32'd1);
    key[1] = 1'b1;
    step(10);
    check_eq("b_release_count", 32'(queue_count), 32'd1);
    do_tick();
    check_eq("b_up_to_right", 32'(hd()), 32'b001);

    // three B presses without a tick: third is dropped
    press(1, 10, 12);
    press(1, 10, 12);
    check_eq("fill_count", 32'(queue_count), 32'd2);
    check_eq("fill_no_ovf", 32'(overflow), 32'd0);
    press(1, 10, 12);
    check_eq("full_count", 32'(queue_count), 32'd2);
    check_eq("full_ovf", 32'(overflow), 32'd1);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b010);
    for (int i = 0; i < 2; i++) begin
      do_tick();
      check_eq("bb_turn_pulse", 32'(turn_applied), 32'd1);
      check_eq("bb_heading", 32'(hd()), 32'(exp_q.pop_front()));
    end
    do_tick();
    check_eq("empty_tick_heading", 32'(hd()), 32'b010);
    check_eq("empty_tick_turn", 32'(turn_applied), 32'd0);
    check_eq("empty_tick_count", 32'(queue_count), 32'd0);

    // clear, then both keys at once: A kept, B dropped
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_eq("clr_ovf", 32'(overflow), 32'd0);
    check_eq("clr_heading", 32'(hd()), 32'h0);
    key = 2'b00;
    step(10);
    key = 2'b11;
    step(12);
    check_eq("both_count", 32'(queue_count), 32'd1);
    check_eq("both_ovf", 32'(overflow), 32'd1);
    press(1, 10, 12);
    check_eq("both_then_b", 32'(queue_count), 32'd2);

    // full queue: push of A coincides with a tick
    key[0] = 1'b0;
    step(5);
    move_tick = 1'b1;
    step(1);
    move_tick = 1'b0;
    check_eq("pushpop_count", 32'(queue_count), 32'd2);
    check_eq("pushpop_heading", 32'(hd()), 32'b101);
    check_eq("pushpop_turn", 32'(turn_applied), 32'd1);
    step(4);
    key[0] = 1'b1;
    step(12);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b101);
    for (int i = 0; i < 2; i++) begin
      do_tick();
      check_eq("order_heading", 32'(hd()), 32'(exp_q.pop_front()));
    end
    check_eq("order_count", 32'(queue_count), 32'd0);

    // clear wins over a simultaneous tick on a two-entry queue
    press(0, 10, 12);
    press(0, 10, 12);
    check_eq("pre_clr_count", 32'(queue_count), 32'd2);
    clear     = 1'b1;
    move_tick = 1'b1;
    step(1);
    clear     = 1'b0;
    move_tick = 1'b0;
    check_eq("clrtick_count", 32'(queue_count), 32'd0);
    check_eq("clrtick_heading", 32'(hd()), 32'h0);
    check_eq("clrtick_ovf", 32'(overflow), 32'd0);
    check_eq("clrtick_turn", 32'(turn_applied), 32'd0);
    step(1);
    check_eq("clrtick_turn_next", 32'(turn_applied), 32'd0);

    // a key held across clear does not fire again
    key[0] = 1'b0;
    step(8);
    check_eq("held_count", 32'(queue_count), 32'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(10);
    check_eq("held_no_refire", 32'(queue_count), 32'd0);
    key[0] = 1'b1;
    step(10);

    // async reset in the middle of a debounce, with a non-default heading
    press(1, 10, 12);
    do_tick();
    check_eq("pre_rst_heading", 32'(hd()), 32'b100);
    key[1] = 1'b0;
    step(3);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_heading", 32'(hd()), 32'h0);
    check_eq("async_count", 32'(queue_count), 32'd0);
    check_eq("async_ovf", 32'(overflow), 32'd0);
    check_eq("async_turn", 32'(turn_applied), 32'd0);
    key = 2'b11;
    step(2);
    reset = 1'b0;
    step(10);
    check_eq("post_rst_count", 32'(queue_count), 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_turn_queue.md
Name: key_turn_queue

Overview:
Input stage that sits directly upstream of the snake game core. It synchronises and debounces the two active-low push buttons and turns each clean press into a turn command. Commands are buffered in a small FIFO and applied one per move tick, so presses between moves are never lost or double-applied. The block owns the heading state (direction/horizontal/vertical) that the game core reads when it computes its next step.

Parameters:
DEBOUNCE_CYCLES, 20000, consecutive stable samples required before a key's debounced level changes (must be >= 2)
QUEUE_DEPTH, 2, number of turn commands the FIFO holds (power of two, 2..8)
CNT_W, 16, width of the per-key debounce counters (must hold DEBOUNCE_CYCLES)

Ports:
clockInp  in  1  system clock
reset  in  1  asynchronous active-high reset
KEY  in  2  raw push buttons, active-low; KEY[0] = turn A, KEY[1] = turn B
move_tick  in  1  one-cycle pulse from the game core at each snake move
clear  in  1  synchronous game restart; flushes the queue and resets the heading
direction  out  1  0 = horizontal, 1 = vertical
horizontal  out  1  0 = right, 1 = left (meaningful when direction = 0)
vertical  out  1  0 = down, 1 = up (meaningful when direction = 1)
turn_applied  out  1  one-cycle pulse when a queued command updates the heading
queue_count  out  4  number of commands currently queued (0..QUEUE_DEPTH)
overflow  out  1  sticky: at least one press was dropped

Behaviour:
- Reset (asynchronous, active-high) sets: heading = right (direction=0, horizontal=0, vertical=0); queue empty; queue_count=0; turn_applied=0; overflow=0; synchroniser flops=1; debounced levels=1 (released); debounce counters=0.
- Synchroniser: each KEY bit passes through two flops on clockInp before debounce.
- Debounce, per key:
  - If the synced level equals the debounced level, the counter resets to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced level and the counter resets.
  - A glitch shorter than DEBOUNCE_CYCLES restarts the count and produces no change.
- Press event: a debounced 1->0 transition, one cycle wide. Release events are ignored. Holding a key yields exactly one event.
- Latency: a clean press produces its event 2+DEBOUNCE_CYCLES cycles after the KEY edge (±1).
- Push rules:
  - A press event pushes the turn code (0 = A, 1 = B).
  - If both keys produce events in the same cycle, A is pushed and B is dropped; this sets overflow.
  - A push while queue_count = QUEUE_DEPTH is dropped and sets overflow.
- Pop rules:
  - On move_tick with queue non-empty, the head entry is popped. The heading is updated on the following clock edge, with turn_applied=1 for that one cycle.
  - move_tick on an empty queue does nothing.
- Push and pop in the same cycle:
  - Both take effect and queue_count is unchanged.
  - When full, the pop frees space, so the push succeeds.
  - When empty, no bypass: the new entry waits for the next move_tick.
- Heading update, turn A (cycle right -> up -> left -> down -> right):
  - dir0 h0 -> dir1 v1
  - dir1 v1 -> dir0 h1
  - dir0 h1 -> dir1 v0
  - dir1 v0 -> dir0 h0
- Heading update, turn B: the inverse cycle (right -> down -> left -> up -> right).
- Unused bits hold their value: horizontal is unchanged while vertical, and vertical unchanged while horizontal.
- clear has priority over push, pop and tick in the same cycle. Next edge: queue empty, heading = right, overflow=0, turn_applied=0. Debounce state is untouched, so a held key does not re-fire.
- Pointers: read and write pointers wrap modulo QUEUE_DEPTH; queue_count is kept in a separate register, 0..QUEUE_DEPTH.
- Reset asserted mid-debounce or mid-pop: all state returns to reset values immediately; no partial heading update survives.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2.)
- Reset, then hold KEY=2'b11 for 50 cycles -> heading right (0,0,0), queue_count=0, overflow=0, turn_applied never asserts.
- KEY[0] low for 20 cycles, then one move_tick -> queue_count goes 0->1 about 6 cycles after the edge; the cycle after the tick: direction=1, vertical=1, turn_applied=1 for exactly 1 cycle, queue_count=0.
- 3-cycle low glitch on KEY[1] -> no event, queue_count stays 0; then KEY[1] held 40 cycles -> exactly one push.
- Three separate KEY[1] presses with no tick -> queue_count=2, overflow=1. Then two ticks -> heading right->down->left (dir0, h1). A third tick -> no change, no turn_applied.
- Both keys pressed simultaneously -> queue_count=1 (entry A), overflow=1. With queue full, push and tick in the same cycle -> queue_count stays 2, FIFO order preserved.
- Queue holding 2 entries, assert clear together with move_tick -> queue_count=0, heading right, overflow=0, no turn_applied. Async reset pulsed mid-debounce -> all outputs at reset values before the next edge.
